// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Purpose  : Host-to-device PS/2 transmitter. Sends one command byte to the
//             device using the request-to-send sequence, then checks the
//             device ACK. Both open-drain lines are driven through
//             low-enables; the top level ties pin = oe ? 1'b0 : 1'bz.
//  Ports    : clk, rst_n        system clock, async active-low reset
//             ps2_clk/ps2_data  sampled PS/2 pins
//             ps2_clk_oe        1 = pull PS/2 clock low
//             ps2_data_oe       1 = pull PS/2 data low
//             tx_data/tx_valid  command byte and send request
//             tx_ready          1 = idle, byte accepted on tx_valid
//             busy              1 = transaction in progress
//             done              one-cycle pulse at end of transaction
//             ack_err           valid with done, 1 = device did not ACK
//             timeout           one-cycle pulse on watchdog abort
//  Options  : PS2_TX_TIMEOUT_EN  builds the watchdog; otherwise timeout = 0
//  Revision : 1.0  initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int c_CNT_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_INH_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_RTS_LAST = c_CNT_W'(RTS_CYCLES - 1);
    // bitcnt value seen when the 11th falling edge arrives
    localparam logic [3:0] c_LAST_FALL = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_RTS       = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_clk_meta;
    logic               r_clk_sync;
    logic               r_clk_prev;
    logic               r_data_meta;
    logic               r_data_sync;
    logic               w_fall;

    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_bitcnt;
    logic [7:0]         r_byte;
    logic               r_parity;
    logic               r_ack_err;

    logic               w_accept;
    logic               w_ack_sample;
    logic               w_wdog_hit;
    logic [15:0]        w_frame;
    logic               w_bit;

    assign w_fall = r_clk_prev & ~r_clk_sync;

    // Frame indexed by bitcnt: start, b0..b7, parity, stop. Indices past the
    // stop bit read as 1 so the data line stays released.
    assign w_frame = {5'b11111, 1'b1, r_parity, r_byte, 1'b0};
    assign w_bit   = w_frame[r_bitcnt];

`ifdef PS2_TX_TIMEOUT_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

    logic [c_WD_W-1:0] r_wdog;
    logic              w_wdog_run;

    // Runs from SEND entry until the transaction leaves the device-paced part.
    assign w_wdog_run = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
    assign w_wdog_hit = w_wdog_run && (r_wdog == c_WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else if (!w_wdog_run) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + c_WD_W'(1);
        end
    end
`else
    // No watchdog in this build; the parameter only keeps the interface stable.
    assign w_wdog_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    assign timeout = w_wdog_hit;
    // On a watchdog abort the error must be visible in the same cycle as done.
    assign ack_err = r_ack_err | w_wdog_hit;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and line/handshake outputs. Outputs decode from the state so
    // an asynchronous reset releases both lines immediately.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        ps2_clk_oe   = 1'b0;
        ps2_data_oe  = 1'b0;
        tx_ready     = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        w_accept     = 1'b0;
        w_ack_sample = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy     = 1'b0;
                tx_ready = 1'b1;
                if (tx_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (r_cnt == c_INH_LAST) begin
                    w_state_nxt = S_RTS;
                end
            end
            S_RTS: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                if (r_cnt == c_RTS_LAST) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                ps2_data_oe = ~w_bit;
                if (w_fall && (r_bitcnt == c_LAST_FALL)) begin
                    w_ack_sample = 1'b1;
                    w_state_nxt  = S_ACK;
                end
            end
            S_ACK: begin
                w_state_nxt = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (r_clk_sync && r_data_sync) begin
                    done        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_wdog_hit) begin
            ps2_clk_oe  = 1'b0;
            ps2_data_oe = 1'b0;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // Synchronizers, byte latch, delay counter, falling-edge counter, ACK flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Idle-high reset values avoid a false fall after reset release.
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
            r_cnt       <= '0;
            r_bitcnt    <= '0;
            r_byte      <= '0;
            r_parity    <= 1'b0;
            r_ack_err   <= 1'b0;
        end else begin
            r_clk_meta  <= ps2_clk;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= ps2_data;
            r_data_sync <= r_data_meta;

            if (w_accept) begin
                r_byte   <= tx_data;
                r_parity <= ~^tx_data;
            end

            if (r_state != w_state_nxt) begin
                r_cnt <= '0;
            end else if ((r_state == S_INHIBIT) || (r_state == S_RTS)) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if (r_state == S_RTS) begin
                r_bitcnt <= '0;
            end else if ((r_state == S_SEND) && w_fall) begin
                r_bitcnt <= r_bitcnt + 4'd1;
            end

            if (w_accept) begin
                r_ack_err <= 1'b0;
            end else if (w_wdog_hit) begin
                r_ack_err <= 1'b1;
            end else if (w_ack_sample) begin
                r_ack_err <= r_data_sync;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_host_tx
//  Purpose  : Self-checking bench for ps2_host_tx with a PS/2 device model
//             that clocks the frame in, decodes it and optionally ACKs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    logic ps2_clk, ps2_data;
    logic ps2_clk_oe, ps2_data_oe, tx_ready, busy, done, ack_err, timeout;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic done_ack = 1'b0;
    int to_cnt = 0;
    int to_cyc = 0;
    int acc_cyc = 0;

    // Wired-AND open-drain lines with pull-ups
    assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_ack = ack_err;
            done_cyc = cyc;
        end
        if (timeout) begin
            to_cnt = to_cnt + 1;
            to_cyc = cyc;
        end
        if (tx_valid && tx_ready) acc_cyc = cyc;
    end

    initial begin
        #30_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_send(output bit ok);
        int n;
        n = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 20000) begin
            tick;
            n++;
        end
        ok = (n < 20000);
    endtask

    // Device side: clocks 10 bits in after the start bit, then the ACK clock.
    task automatic dev_rx(input bit do_ack, output logic [10:0] frame, output bit ok);
        wait_send(ok);
        frame = '0;
        if (!ok) return;
        frame[0] = ps2_data;
        for (int k = 1; k <= 10; k++) begin
            repeat (HALF) tick;
            dev_clk_low = 1'b1;
            repeat (HALF) tick;
            frame[k] = ps2_data;
            dev_clk_low = 1'b0;
        end
        repeat (HALF - 3) tick;
        if (do_ack) dev_data_low = 1'b1;
        repeat (3) tick;
        dev_clk_low = 1'b1;
        repeat (HALF) tick;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(input int snap, output bit seen);
        int n;
        n = 0;
        while (done_cnt == snap && n < 500) begin
            tick;
            n++;
        end
        seen = (done_cnt != snap);
    endtask

    task automatic run_tx(input logic [7:0] b, input bit do_ack,
                          output logic [10:0] frame, output bit ok, output bit seen);
        int snap;
        tick;
        tx_data  = b;
        tx_valid = 1'b1;
        tick;
        tx_valid = 1'b0;
        snap = done_cnt;
        dev_rx(do_ack, frame, ok);
        seen = 1'b0;
        if (ok) wait_done(snap, seen);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick;
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_oe: clk_oe=%b data_oe=%b, required 0/0", ps2_clk_oe, ps2_data_oe);
        end
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: tx_ready=%b busy=%b, required 1/0", tx_ready, busy);
        end
        checks++;
        if (done !== 1'b0 || ack_err !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: done=%b ack_err=%b timeout=%b, required 0/0/0", done, ack_err, timeout);
        end
        rst_n = 1'b1;
        repeat (3) tick;
    endtask

    task automatic test_send_ed;
        int inh, rts, snap;
        logic [10:0] fr, exp_fr;
        bit ok, seen;
        exp_fr = {1'b1, 1'b1, 8'hED, 1'b0};
        tick;
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        tick;
        tx_valid = 1'b0;
        checks++;
        if (tx_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ed_accept: tx_ready=%b busy=%b, required 0/1", tx_ready, busy);
        end
        inh = 0;
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && inh < 10000) begin
            inh++;
            tick;
        end
        rts = 0;
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1 && rts < 1000) begin
            rts++;
            tick;
        end
        checks++;
        if (inh != 5000) begin
            errors++;
            $display("FAIL ed_inhibit: %0d cycles, required 5000", inh);
        end
        checks++;
        if (rts != 50) begin
            errors++;
            $display("FAIL ed_rts: %0d cycles, required 50", rts);
        end
        snap = done_cnt;
        dev_rx(1'b1, fr, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ed_send_start: SEND not reached, required clk released with data low");
        end
        checks++;
        if (fr !== exp_fr) begin
            errors++;
            $display("FAIL ed_frame: got %b, required %b", fr, exp_fr);
        end
        wait_done(snap, seen);
        checks++;
        if (!seen || done_ack !== 1'b0) begin
            errors++;
            $display("FAIL ed_done: seen=%b ack_err=%b, required 1/0", seen, done_ack);
        end
        tick;
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ed_idle: tx_ready=%b busy=%b, required 1/0", tx_ready, busy);
        end
    endtask

    task automatic test_parity;
        logic [10:0] fr, exp_fr;
        bit ok, seen;
        exp_fr = {1'b1, 1'b0, 8'h01, 1'b0};
        run_tx(8'h01, 1'b1, fr, ok, seen);
        checks++;
        if (fr !== exp_fr) begin
            errors++;
            $display("FAIL par_01_frame: got %b, required %b", fr, exp_fr);
        end
        checks++;
        if (!seen || done_ack !== 1'b0) begin
            errors++;
            $display("FAIL par_01_done: seen=%b ack_err=%b, required 1/0", seen, done_ack);
        end
        exp_fr = {1'b1, 1'b1, 8'hFF, 1'b0};
        run_tx(8'hFF, 1'b1, fr, ok, seen);
        checks++;
        if (fr !== exp_fr) begin
            errors++;
            $display("FAIL par_ff_frame: got %b, required %b", fr, exp_fr);
        end
        checks++;
        if (!seen || done_ack !== 1'b0) begin
            errors++;
            $display("FAIL par_ff_done: seen=%b ack_err=%b, required 1/0", seen, done_ack);
        end
    endtask

    task automatic test_no_ack;
        logic [10:0] fr, exp_fr;
        bit ok, seen;
        exp_fr = {1'b1, 1'b1, 8'hF0, 1'b0};
        run_tx(8'hF0, 1'b0, fr, ok, seen);
        checks++;
        if (fr !== exp_fr) begin
            errors++;
            $display("FAIL noack_frame: got %b, required %b", fr, exp_fr);
        end
        checks++;
        if (!seen || done_ack !== 1'b1) begin
            errors++;
            $display("FAIL noack_done: seen=%b ack_err=%b, required 1/1", seen, done_ack);
        end
        tick;
        checks++;
        if (tx_ready !== 1'b1 || ack_err !== 1'b1) begin
            errors++;
            $display("FAIL noack_hold: tx_ready=%b ack_err=%b, required 1/1", tx_ready, ack_err);
        end
    endtask

    task automatic test_reset_mid_send;
        logic [10:0] fr, exp_fr;
        bit ok, seen;
        tick;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick;
        tx_valid = 1'b0;
        wait_send(ok);
        for (int k = 1; k <= 4; k++) begin
            repeat (HALF) tick;
            dev_clk_low = 1'b1;
            if (k < 4) begin
                repeat (HALF) tick;
                dev_clk_low = 1'b0;
            end
        end
        repeat (5) tick;
        // bit b3 of 0x55 is 0, so the host is pulling data low here
        checks++;
        if (ps2_data_oe !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_b3: data_oe=%b, required 1", ps2_data_oe);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL rst_async_oe: clk_oe=%b data_oe=%b, required 0/0", ps2_clk_oe, ps2_data_oe);
        end
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_async_hs: tx_ready=%b busy=%b, required 1/0", tx_ready, busy);
        end
        dev_clk_low = 1'b0;
        repeat (2) tick;
        rst_n = 1'b1;
        repeat (2) tick;
        exp_fr = {1'b1, 1'b0, 8'hF4, 1'b0};
        run_tx(8'hF4, 1'b1, fr, ok, seen);
        checks++;
        if (fr !== exp_fr) begin
            errors++;
            $display("FAIL rst_f4_frame: got %b, required %b", fr, exp_fr);
        end
        checks++;
        if (!seen || done_ack !== 1'b0) begin
            errors++;
            $display("FAIL rst_f4_done: seen=%b ack_err=%b, required 1/0", seen, done_ack);
        end
    endtask

    task automatic test_idle_falls;
        for (int k = 0; k < 3; k++) begin
            repeat (HALF) tick;
            dev_clk_low = 1'b1;
            repeat (HALF) tick;
            dev_clk_low = 1'b0;
        end
        repeat (4) tick;
        checks++;
        if (busy !== 1'b0 || tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL idle_falls: busy=%b tx_ready=%b clk_oe=%b data_oe=%b, required 0/1/0/0",
                     busy, tx_ready, ps2_clk_oe, ps2_data_oe);
        end
    endtask

    task automatic test_back_to_back;
        logic [10:0] fr, exp_fr;
        bit ok, seen;
        int snap, n;
        tick;
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        tick;
        tx_data  = 8'h34;
        snap = done_cnt;
        dev_rx(1'b1, fr, ok);
        exp_fr = {1'b1, 1'b1, 8'h12, 1'b0};
        checks++;
        if (fr !== exp_fr) begin
            errors++;
            $display("FAIL b2b_first_frame: got %b, required %b", fr, exp_fr);
        end
        wait_done(snap, seen);
        checks++;
        if (!seen || done_ack !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_done: seen=%b ack_err=%b, required 1/0", seen, done_ack);
        end
        tick;
        checks++;
        if (acc_cyc != done_cyc + 1) begin
            errors++;
            $display("FAIL b2b_accept_cycle: accept at %0d, required %0d", acc_cyc, done_cyc + 1);
        end
        n = 0;
        while (tx_ready === 1'b1 && n < 10) begin
            tick;
            n++;
        end
        tx_valid = 1'b0;
        snap = done_cnt;
        dev_rx(1'b1, fr, ok);
        exp_fr = {1'b1, 1'b0, 8'h34, 1'b0};
        checks++;
        if (fr !== exp_fr) begin
            errors++;
            $display("FAIL b2b_second_frame: got %b, required %b", fr, exp_fr);
        end
        wait_done(snap, seen);
        checks++;
        if (!seen || done_ack !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_done: seen=%b ack_err=%b, required 1/0", seen, done_ack);
        end
    endtask

`ifdef PS2_TX_TIMEOUT_EN
    task automatic test_timeout;
        bit ok;
        int s, snapd, snapt, n;
        tick;
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        tick;
        tx_valid = 1'b0;
        wait_send(ok);
        s     = cyc;
        snapd = done_cnt;
        snapt = to_cnt;
        n = 0;
        while (to_cnt == snapt && n < 1100000) begin
            tick;
            n++;
        end
        checks++;
        if (to_cnt == snapt || to_cyc - s != 999999) begin
            errors++;
            $display("FAIL to_pulse: seen=%0d after %0d cycles, required 1 after 999999", to_cnt - snapt, to_cyc - s);
        end
        checks++;
        if (done_cnt == snapd || done_cyc != to_cyc || done_ack !== 1'b1) begin
            errors++;
            $display("FAIL to_done: done_cyc=%0d ack_err=%b, required %0d/1", done_cyc, done_ack, to_cyc);
        end
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL to_release: clk_oe=%b data_oe=%b tx_ready=%b, required 0/0/1",
                     ps2_clk_oe, ps2_data_oe, tx_ready);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_send_ed;
        test_parity;
        test_no_ack;
        test_reset_mid_send;
        test_idle_falls;
        test_back_to_back;
`ifdef PS2_TX_TIMEOUT_EN
        test_timeout;
`else
        checks++;
        if (to_cnt != 0) begin
            errors++;
            $display("FAIL no_timeout: %0d pulses, required 0", to_cnt);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
